ac_motor_ramp_control: RTL
==========================

// Module: ac_motor_ramp_control
// PURPOSE
//  Parametrised successor of the fixed-setpoint AC motor controller. Turns a
//  POWER/ENABLE/DIR_CMD command into slew-limited AMPLITUDE and FREQUENCY words
//  plus CW/CCW enables for the sine/PWM stage downstream.
//  Direction reversal is safe: ramp to zero, dead time, then ramp up the other way.
// PARAMETERS
//  RESOLUTION_BITS  12               width W of POWER/AMPLITUDE/FREQUENCY
//  PWR_MAX          2**(W-1)-1       clamp for internal power; keeps AMPLITUDE signed-positive
//  RAMP_STEP        16               max |change| of internal power per ramp tick
//  RAMP_DIV         1024             CLK cycles per ramp tick (>=1)
//  DEAD_CYCLES      256              CLK cycles with CW=CCW=0 between directions (>=1)
// PORTS
//  CLK        in   1  system clock, all logic on rising edge
//  RST        in   1  synchronous, active-high reset
//  ENABLE     in   1  1 = drive motor; 0 = ramp down and stop
//  POWER      in   W  unsigned power setpoint; values > PWR_MAX clamp to PWR_MAX
//  DIR_CMD    in   1  0 = CW, 1 = CCW
//  FREQUENCY  out  W  unsigned frequency/period word = 2**W-1 - power_int
//  AMPLITUDE  out  W  signed amplitude = power_int (0..PWR_MAX)
//  CW         out  1  clockwise drive enable
//  CCW        out  1  counter-clockwise drive enable
//  AT_TARGET  out  1  power_int == current target and state RUN
// BEHAVIOUR
//  Reset (sync, RST=1 at posedge): state STOP, power_int=0, dir_q=0, prescaler=0,
//   dead counter=0, AMPLITUDE=0, FREQUENCY=2**W-1, CW=CCW=0, AT_TARGET=0.
//  RST dominates every other input; reset mid-ramp returns to the reset values in one cycle.
//  Prescaler: counts 0..RAMP_DIV-1, tick=1 for one cycle at RAMP_DIV-1, then wraps to 0.
//   RAMP_DIV=1 -> tick every cycle. Free-running in all states outside reset.
//  target = (state==RUN && ENABLE) ? min(POWER,PWR_MAX) : 0.
//  On tick: power_int moves toward target by min(RAMP_STEP,|target-power_int|);
//   no overshoot, no wrap; unchanged when equal. Width W+1 internally for compare.
//  States:
//   STOP : power_int==0, CW=CCW=0. ENABLE=1 -> dir_q<=DIR_CMD, go RUN.
//   RUN  : ramp toward target. DIR_CMD!=dir_q -> BRAKE (DEAD if power_int==0).
//          ENABLE=0 -> BRAKE.
//   BRAKE: target 0. On power_int==0: ENABLE=1 -> DEAD, else -> STOP.
//   DEAD : CW=CCW=0; count DEAD_CYCLES; dir_q<=DIR_CMD sampled on the last
//          DEAD cycle; then RUN. ENABLE=0 during DEAD -> STOP at end of count.
//  DIR_CMD toggles during BRAKE/DEAD: only the value at DEAD end is used; a
//   differing value afterwards starts a new reversal from RUN.
//  ENABLE re-asserted during BRAKE: BRAKE completes (to zero) before any ramp-up.
//  Outputs registered from power_int/state/dir_q: one CLK cycle latency.
//   CW  = (state in RUN,BRAKE) && dir_q==0;  CCW = (state in RUN,BRAKE) && dir_q==1.
//   CW and CCW are never 1 together; both 0 for >= DEAD_CYCLES between directions.
//  AT_TARGET: 1 only in RUN with power_int==target (incl. target 0 when POWER=0).
// STRUCTURE
//  Package ac_motor_pkg: state encoding (STOP,RUN,BRAKE,DEAD), DIR_CW/DIR_CCW
//   constants, default RESOLUTION_BITS.
//  Sub-module ac_ramp_prescaler (RAMP_DIV counter -> 1-cycle tick); FSM, ramp
//   arithmetic and output registers stay in this module.
// TESTING (W=12, PWR_MAX=2047, RAMP_STEP=16, RAMP_DIV=4, DEAD_CYCLES=8)
//  1 Reset: RST=1 2 cycles -> AMPLITUDE=0, FREQUENCY=4095, CW=CCW=0, AT_TARGET=0.
//  2 Ramp up: ENABLE=1,DIR_CMD=0,POWER=100 -> +16 per 4 cycles, 96 then 100 (no
//    overshoot); FREQUENCY=3995; CW=1; AT_TARGET=1.
//  3 Clamp: POWER=4000 -> AMPLITUDE settles at 2047, FREQUENCY=2048.
//  4 Reversal from 100: DIR_CMD=1 -> ramps to 0, CW=CCW=0 for 8 cycles, then
//    CCW=1 and ramp to 100; never CW&CCW=1.
//  5 Disable mid-ramp at 48: ENABLE=0 -> ramps 32,16,0 -> STOP, CW=CCW=0.
//  6 RST=1 mid-ramp at 64 together with DIR_CMD toggle -> next cycle reset
//    values; ENABLE still 1 -> restarts from 0 in latched direction.

Source files
------------

// File: rtl/ac_motor_pkg.sv
// Shared types and constants for the AC motor ramp controller.
package ac_motor_pkg;

  localparam int unsigned DEFAULT_RESOLUTION_BITS = 12;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_BRAKE,
    ST_DEAD
  } motor_state_e;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

endpackage

// File: rtl/ac_ramp_prescaler.sv
// Free-running divider producing a one-cycle ramp tick every RAMP_DIV clocks.
module ac_ramp_prescaler #(
  parameter int unsigned RAMP_DIV = 1024
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/ac_motor_ramp_control.sv
// Slew-limited AC motor command generator with safe, dead-timed direction reversal.
module ac_motor_ramp_control
  import ac_motor_pkg::*;
#(
  parameter int unsigned RESOLUTION_BITS = DEFAULT_RESOLUTION_BITS,
  parameter int unsigned PWR_MAX         = 2**(RESOLUTION_BITS-1) - 1,
  parameter int unsigned RAMP_STEP       = 16,
  parameter int unsigned RAMP_DIV        = 1024,
  parameter int unsigned DEAD_CYCLES     = 256
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ENABLE,
  input  logic [RESOLUTION_BITS-1:0] POWER,
  input  logic                       DIR_CMD,
  output logic [RESOLUTION_BITS-1:0] FREQUENCY,
  output logic [RESOLUTION_BITS-1:0] AMPLITUDE,
  output logic                       CW,
  output logic                       CCW,
  output logic                       AT_TARGET
);

  localparam int unsigned W     = RESOLUTION_BITS;
  localparam int unsigned WX    = W + 1;
  localparam int unsigned DCW   = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [WX-1:0]  PWR_MAX_X = WX'(PWR_MAX);
  localparam logic [WX-1:0]  STEP_X    = WX'(RAMP_STEP);
  localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_CYCLES - 1);

  motor_state_e   state, state_n;
  logic           dir_q, dir_n;
  logic [WX-1:0]  power_x, power_n;
  logic [WX-1:0]  power_clamped, target, delta, step;
  logic [DCW-1:0] dead_cnt;
  logic           tick, power_zero, drive;

  ac_ramp_prescaler #(.RAMP_DIV(RAMP_DIV)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  // Ramp arithmetic is done one bit wider so the compare and step never wrap.
  always_comb begin
    power_clamped = ({1'b0, POWER} > PWR_MAX_X) ? PWR_MAX_X : {1'b0, POWER};
    target        = (state == ST_RUN && ENABLE) ? power_clamped : '0;
    delta         = (target > power_x) ? (target - power_x) : (power_x - target);
    step          = (delta > STEP_X) ? STEP_X : delta;
    power_n       = power_x;
    if (tick) begin
      if (target > power_x)
        power_n = power_x + step;
      else
        power_n = power_x - step;
    end
  end

  assign power_zero = (power_x == '0);
  assign drive      = (state == ST_RUN) || (state == ST_BRAKE);

  always_comb begin
    state_n = state;
    dir_n   = dir_q;
    unique case (state)
      ST_STOP: begin
        if (ENABLE) begin
          state_n = ST_RUN;
          dir_n   = DIR_CMD;
        end
      end
      ST_RUN: begin
        if (!ENABLE)
          state_n = ST_BRAKE;
        else if (DIR_CMD != dir_q)
          state_n = power_zero ? ST_DEAD : ST_BRAKE;
      end
      ST_BRAKE: begin
        if (power_zero)
          state_n = ENABLE ? ST_DEAD : ST_STOP;
      end
      ST_DEAD: begin
        if (dead_cnt == DEAD_LAST) begin
          dir_n   = DIR_CMD;
          state_n = ENABLE ? ST_RUN : ST_STOP;
        end
      end
      default: state_n = ST_STOP;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_STOP;
      dir_q     <= DIR_CW;
      power_x   <= '0;
      dead_cnt  <= '0;
      AMPLITUDE <= '0;
      FREQUENCY <= '1;
      CW        <= 1'b0;
      CCW       <= 1'b0;
      AT_TARGET <= 1'b0;
    end else begin
      state     <= state_n;
      dir_q     <= dir_n;
      power_x   <= power_n;
      dead_cnt  <= (state == ST_DEAD && state_n == ST_DEAD) ? dead_cnt + DCW'(1) : '0;
      AMPLITUDE <= power_x[W-1:0];
      FREQUENCY <= ~power_x[W-1:0];
      CW        <= drive && (dir_q == DIR_CW);
      CCW       <= drive && (dir_q == DIR_CCW);
      AT_TARGET <= (state == ST_RUN) && (power_x == target);
    end
  end

endmodule
